bcp_axi4_burst_slave: RTL

AXI4 (full) memory-mapped slave that sits behind the BCP accelerator's S00_AXI burst port and answers the master VIP / PS burst traffic. It stores 32-bit words in an internal register-file memory. It accepts INCR and FIXED bursts of up to 256 beats on independent write and read channels, and returns OKAY or SLVERR responses. Reading back an 8-beat INCR write must return the identical data.

---
 rtl/bcp_axi4_burst_slave.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/bcp_axi4_burst_slave.sv
// AXI4 burst slave backed by a 32-bit register-file memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, INCR/FIXED bursts,
// OKAY/SLVERR responses.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN     clock, async active-low reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B* write address / data / response
//   S_AXI_AR*, S_AXI_R*           read address / data
//   Cache/prot/qos/region/user    accepted and ignored; BUSER/RUSER tied 0
module bcp_axi4_burst_slave #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic [3:0]                      S_AXI_AWREGION,
    input  logic                            S_AXI_AWUSER,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WUSER,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BUSER,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic [3:0]                      S_AXI_ARREGION,
    input  logic                            S_AXI_ARUSER,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RUSER,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int IW    = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IW;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam logic [IW-1:0] ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    logic [DW-1:0] mem [DEPTH];

    // Ready enable: holds AWREADY/ARREADY low until the first edge after reset.
    logic ready_en;

    w_state_t                    w_state, w_next;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id;
    logic [IW-1:0]               w_addr;
    logic [7:0]                  w_len;
    logic [7:0]                  w_cnt;
    logic                        w_fixed;
    logic                        w_err;
    logic                        w_lerr;

    r_state_t                    r_state, r_next;
    logic [C_S_AXI_ID_WIDTH-1:0] r_id;
    logic [IW-1:0]               r_addr;
    logic [7:0]                  r_len;
    logic [7:0]                  r_cnt;
    logic                        r_fixed;
    logic                        r_err;
    logic [DW-1:0]               rdata;

    logic aw_hs, w_hs, w_end;
    logic ar_hs, r_hs, r_end;
    logic aw_bad, ar_bad;
    logic [IW-1:0] ar_idx;

    function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || (size != 3'd2);
    endfunction

    assign aw_bad = bad_req(S_AXI_AWBURST, S_AXI_AWSIZE);
    assign ar_bad = bad_req(S_AXI_ARBURST, S_AXI_ARSIZE);
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    assign S_AXI_AWREADY = ready_en && (w_state == W_IDLE);
    assign S_AXI_WREADY  = (w_state == W_DATA);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BID     = w_id;
    assign S_AXI_BRESP   = {w_err | w_lerr, 1'b0};
    assign S_AXI_BUSER   = 1'b0;

    assign S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RID     = r_id;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = {r_err, 1'b0};
    assign S_AXI_RLAST   = (r_state == R_DATA) && (r_cnt == r_len);
    assign S_AXI_RUSER   = 1'b0;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign w_end = w_hs && (w_cnt == w_len);
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID && S_AXI_RREADY;
    assign r_end = r_hs && S_AXI_RLAST;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT,
                         S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_AWUSER,
                         S_AXI_WUSER, S_AXI_ARLOCK, S_AXI_ARCACHE,
                         S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
                         S_AXI_ARUSER};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write FSM
    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_end) w_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
            w_lerr  <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                w_id    <= S_AXI_AWID;
                w_addr  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                w_len   <= S_AXI_AWLEN;
                w_cnt   <= '0;
                w_fixed <= (S_AXI_AWBURST == 2'b00);
                w_err   <= aw_bad;
                w_lerr  <= 1'b0;
            end
            if (w_hs) begin
                w_cnt <= w_cnt + 8'd1;
                if (!w_fixed) w_addr <= w_addr + ONE;
                // WLAST must appear on exactly the final beat.
                if (S_AXI_WLAST != (w_cnt == w_len)) w_lerr <= 1'b1;
            end
        end
    end

    // Memory is deliberately not reset so contents survive ARESETN.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs && !w_err) begin
            for (int b = 0; b < SW; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_addr][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Read FSM
    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_end) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // RDATA is a registered load, so a same-cycle write yields the old word.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
            rdata   <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                r_id    <= S_AXI_ARID;
                r_len   <= S_AXI_ARLEN;
                r_cnt   <= '0;
                r_fixed <= (S_AXI_ARBURST == 2'b00);
                r_err   <= ar_bad;
                rdata   <= ar_bad ? '0 : mem[ar_idx];
                r_addr  <= (S_AXI_ARBURST == 2'b00) ? ar_idx : ar_idx + ONE;
            end else if (r_hs && !S_AXI_RLAST) begin
                r_cnt <= r_cnt + 8'd1;
                rdata <= r_err ? '0 : mem[r_addr];
                if (!r_fixed) r_addr <= r_addr + ONE;
            end
        end
    end

endmodule
